// File: rtl/encoder_pass_scheduler.sv
// Sequences multi-pass encoder jobs: clears the encoder, runs it, checks the
// written line count and ping-pongs the line-memory banks between passes.
module encoder_pass_scheduler #(
  parameter int LINES      = 64,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] num_passes,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [4:0] pass_cnt,
  output logic       enc_rst,
  output logic       enc_rotate_en,
  input  logic       enc_done,
  input  logic       enc_wr_en,
  output logic       rd_bank,
  output logic       wr_bank,
  output logic       result_bank
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [6:0]    LINE_TGT  = 7'(LINES);

  typedef enum logic [2:0] {IDLE, CLR, RUN, CHECK, FIN, ERR} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      passes_reg, pass_cnt_reg;
  logic [1:0]      err_reg;
  logic [6:0]      line_cnt_reg;
  logic [WW-1:0]   wdog_reg;
  logic [CW-1:0]   clr_cnt_reg;
  logic            done_prev_reg, wr_prev_reg;
  logic            enc_rst_reg, rd_bank_reg, result_bank_reg;
  logic            done_rise, wr_rise, count_ok;
  logic [4:0]      pass_cnt_inc;

  assign done_rise    = enc_done & ~done_prev_reg;
  assign wr_rise      = enc_wr_en & ~wr_prev_reg;
  assign count_ok     = (line_cnt_reg == LINE_TGT);
  assign pass_cnt_inc = pass_cnt_reg + 5'd1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (num_passes != 5'd0) ? CLR : FIN;
      CLR:   if (clr_cnt_reg == CLR_LAST) state_next = RUN;
      // A completion edge beats a watchdog expiry in the same cycle.
      RUN: begin
        if (done_rise)                  state_next = CHECK;
        else if (wdog_reg == WDOG_LAST) state_next = ERR;
      end
      CHECK: begin
        if (!count_ok)                       state_next = ERR;
        else if (pass_cnt_inc == passes_reg) state_next = FIN;
        else                                 state_next = CLR;
      end
      FIN:     state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      passes_reg      <= 5'd0;
      pass_cnt_reg    <= 5'd0;
      err_reg         <= 2'd0;
      line_cnt_reg    <= 7'd0;
      wdog_reg        <= '0;
      clr_cnt_reg     <= '0;
      done_prev_reg   <= 1'b0;
      wr_prev_reg     <= 1'b0;
      enc_rst_reg     <= 1'b1;
      rd_bank_reg     <= 1'b0;
      result_bank_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      enc_rst_reg <= (state_next == CLR);
      clr_cnt_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            passes_reg   <= num_passes;
            pass_cnt_reg <= 5'd0;
            err_reg      <= 2'd0;
            line_cnt_reg <= 7'd0;
          end
        end
        CLR: begin
          clr_cnt_reg   <= clr_cnt_reg + 1'b1;
          line_cnt_reg  <= 7'd0;
          wdog_reg      <= '0;
          done_prev_reg <= 1'b0;
          wr_prev_reg   <= 1'b0;
        end
        RUN: begin
          done_prev_reg <= enc_done;
          wr_prev_reg   <= enc_wr_en;
          wdog_reg      <= wdog_reg + 1'b1;
          if (wr_rise && line_cnt_reg != 7'd127) line_cnt_reg <= line_cnt_reg + 7'd1;
          if (state_next == ERR) err_reg <= 2'd2;
        end
        CHECK: begin
          if (!count_ok) begin
            err_reg <= 2'd1;
          end else begin
            pass_cnt_reg <= pass_cnt_inc;
            if (pass_cnt_inc == passes_reg) result_bank_reg <= ~rd_bank_reg;
            else                            rd_bank_reg     <= ~rd_bank_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == FIN) || (state_reg == ERR);
  assign err           = err_reg;
  assign pass_cnt      = pass_cnt_reg;
  assign enc_rst       = enc_rst_reg;
  assign enc_rotate_en = (state_reg == RUN);
  assign rd_bank       = rd_bank_reg;
  assign wr_bank       = ~rd_bank_reg;
  assign result_bank   = result_bank_reg;

endmodule
